// File: rtl/unit_scheduler.sv
// unit_scheduler: per-tick lane advance of 16 unit slots, round-robin spawn, vblank-aligned publish
module unit_scheduler #(
  parameter logic [8:0] LANE_END = 9'd400,
  parameter logic [8:0] STEP = 9'd1,
  parameter logic [9:0] VBLANK_START = 10'd516
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [9:0]   vCount,
  input  logic         reqP,
  input  logic         reqE,
  input  logic [1:0]   typeP,
  input  logic [1:0]   typeE,
  output logic         ackP,
  output logic         ackE,
  output logic [143:0] unitLocBus,
  output logic [31:0]  unitTypeBus,
  output logic         snapshot,
  output logic         busy,
  output logic         overrun
);
  localparam logic [2:0] IDLE = 3'd0, ADVANCE = 3'd1, SPAWN = 3'd2, WAIT_VB = 3'd3, PUBLISH = 3'd4;
  logic [2:0] r_state;
  logic [3:0] r_idx;
  logic [8:0] r_loc [16];
  logic [1:0] r_type [16];
  logic       r_rr;
  logic       r_overrun;
  logic       w_vp, w_ve, w_full, w_gp, w_ge;
  logic [3:0] w_free;
  logic [9:0] w_sum;
  assign w_vp = reqP && (typeP != 2'b00);
  assign w_ve = reqE && (typeE != 2'b00);
  always_comb begin
    w_full = 1'b1;
    w_free = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (r_type[i] == 2'b00) begin
        w_full = 1'b0;
        w_free = i[3:0];
      end
  end
  // r_rr low names P as the winner when both sides ask
  assign w_gp = !w_full && w_vp && (!w_ve || !r_rr);
  assign w_ge = !w_full && w_ve && (!w_vp || r_rr);
  assign w_sum = {1'b0, r_loc[r_idx]} + {1'b0, STEP};
  assign ackP = !rst && (r_state == SPAWN) && w_gp;
  assign ackE = !rst && (r_state == SPAWN) && w_ge;
  assign snapshot = !rst && (r_state == PUBLISH);
  assign busy = r_state != IDLE;
  assign overrun = r_overrun;
  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_bus
      assign unitLocBus[9*g +: 9] = r_loc[g];
      assign unitTypeBus[2*g +: 2] = r_type[g];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= 4'd0;
      r_rr <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_loc[i] <= 9'd0;
        r_type[i] <= 2'b00;
      end
    end else begin
      if (tick && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (tick) begin
          r_state <= ADVANCE;
          r_idx <= 4'd0;
        end
        ADVANCE: begin
          if (r_type[r_idx] != 2'b00) begin
            if (w_sum >= {1'b0, LANE_END}) begin
              r_type[r_idx] <= 2'b00;
              r_loc[r_idx] <= 9'd0;
            end else r_loc[r_idx] <= w_sum[8:0];
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) r_state <= SPAWN;
        end
        SPAWN: begin
          if (w_gp || w_ge) begin
            r_type[w_free] <= w_gp ? typeP : typeE;
            r_loc[w_free] <= 9'd0;
          end
          if (w_vp && w_ve && !w_full) r_rr <= ~r_rr;
          r_state <= WAIT_VB;
        end
        WAIT_VB: if (vCount >= VBLANK_START) r_state <= PUBLISH;
        PUBLISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/unit_scheduler.md
UNIT_SCHEDULER -- requirements
Module: unit_scheduler

Interface
REQ-001 Parameter LANE_END, default 9'd400: lane length; a unit reaching it is retired.
REQ-002 Parameter STEP, default 9'd1: position increment per game tick.
REQ-003 Parameter VBLANK_START, default 10'd516: first vCount value treated as vertical blanking.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 tick  input  1  one-cycle game-tick pulse, clk domain.
REQ-007 vCount  input  10  current VGA line counter.
REQ-008 reqP / reqE  input  1 each  spawn request, player / enemy; level, held until acked.
REQ-009 typeP / typeE  input  2 each  requested unit type; 2'b00 is invalid.
REQ-010 ackP / ackE  output  1 each  one-cycle grant pulse.
REQ-011 unitLocBus  output  144  slot i location at bits [9i+8:9i], i = 0..15.
REQ-012 unitTypeBus  output  32  slot i type at bits [2i+1:2i]; 2'b00 means the slot is empty.
REQ-013 snapshot  output  1  one-cycle pulse meaning the buses are stable; it drives the renderer's gameSCEN.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-016 FSM states SHALL be IDLE, ADVANCE, SPAWN, WAIT_VB and PUBLISH.
REQ-017 In IDLE, tick=1 SHALL move the FSM to ADVANCE with slot index 0 on the next cycle.
REQ-018 ADVANCE SHALL process exactly one slot per cycle, slots 0 to 15 in order, for 16 cycles total, then move to SPAWN.
REQ-019 ADVANCE rule, occupied slot: if loc+STEP (10-bit sum) >= LANE_END, set type to 00 and loc to 0; otherwise loc <= loc+STEP.
REQ-020 ADVANCE rule, empty slot (type 00): leave the slot unchanged.
REQ-021 SPAWN SHALL take one cycle and grant at most one request per tick.
REQ-022 A request is valid when req=1 and type!=00; a request with type 00 SHALL never be acked and SHALL be ignored.
REQ-023 Arbitration: if only one valid request exists, grant it.
REQ-024 Arbitration: if both are valid, grant the side named by a round-robin pointer, then point it to the other side; the pointer is unchanged when no grant occurs.
REQ-025 The granted request SHALL be placed in the lowest-index empty slot with loc=0 and the requested type.
REQ-026 ack SHALL pulse in the SPAWN cycle itself (the cycle the slot is written).
REQ-027 If all 16 slots are occupied, SPAWN SHALL grant nothing and pending requests SHALL remain pending.
REQ-028 A slot retired in this tick's ADVANCE SHALL be available to SPAWN in the same tick.
REQ-029 After SPAWN the FSM SHALL enter WAIT_VB and stay there until vCount >= VBLANK_START, then enter PUBLISH.
REQ-030 If vCount >= VBLANK_START on WAIT_VB entry, PUBLISH SHALL follow on the next cycle.
REQ-031 PUBLISH SHALL assert snapshot for exactly one cycle, then return to IDLE.
REQ-032 unitLocBus and unitTypeBus SHALL NOT change between PUBLISH and the next ADVANCE.
REQ-033 A tick seen in any state other than IDLE SHALL be dropped (not queued) and SHALL set overrun to 1.
REQ-034 A tick arriving in the same cycle as PUBLISH returns to IDLE is also dropped and sets overrun.
REQ-035 All location arithmetic SHALL use 10 bits; stored locations are always < LANE_END, so the 9-bit slots never wrap.

Reset
REQ-036 On rst=1 at posedge clk: state IDLE, all types 2'b00, all locs 0, ackP/ackE/snapshot 0, busy 0, overrun 0, round-robin pointer set to P.
REQ-037 rst SHALL win over every other input, including in mid-ADVANCE or WAIT_VB; no ack or snapshot SHALL be produced in the reset cycle.

Verification
REQ-038 After reset, hold reqP=1 with typeP=01 and pulse tick, with vCount >= 516 -> ackP on the 18th cycle after tick, slot0 = type 01 / loc 0, snapshot one cycle later, busy low afterwards.
REQ-039 With slot0 at loc 399 (STEP=1), pulse tick -> slot0 type 00 / loc 0 after ADVANCE.
REQ-040 With reqP and reqE held (types 10 and 11), three ticks -> grant order P, E, P, filling slots 0, 1, 2.
REQ-041 With all 16 slots occupied and reqE held -> no ackE.
REQ-042 In the same tick as REQ-041, slot 5 reaches LANE_END -> ackE, and slot 5 gets the new unit at loc 0.
REQ-043 Hold vCount at 100 after SPAWN -> the FSM stays in WAIT_VB and snapshot stays 0; a tick pulsed now sets overrun=1; vCount then steps to 516 -> one snapshot pulse.
REQ-044 Assert rst on ADVANCE cycle 7 -> all outputs at reset values the next cycle; no snapshot follows.
